// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset core.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: opcode/funct codes, FSM state enum, ALU control encoding,
// packed instruction layout and small decode helpers.
package mc_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_EXEC,
    ST_ALUWB,
    ST_ADDIEX,
    ST_ADDIWB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } mc_state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic alu_ctl_t funct_to_alu(input logic [5:0] fn);
    alu_ctl_t ctl;
    case (fn)
      FN_SUB:  ctl = ALU_SUB;
      FN_AND:  ctl = ALU_AND;
      FN_OR:   ctl = ALU_OR;
      FN_SLT:  ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // States that own the memory port while they are active.
  function automatic logic is_mem_state(input mc_state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN register file, two combinational read ports, one write port.
// Latency: reads combinational; write visible the cycle after the write edge.
// Backpressure: none; a write is taken whenever we=1.
// Ports: clk; ra1/ra2 read addresses -> rd1/rd2 data; we/wa/wd write port.
// Register 0 reads as zero and ignores writes. Contents are not reset.
module mc_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [32];

  // Storage array: written in place, no reset, so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regs_q[wa] <= wd;
    end
  end

  // A write and a read of the same index in one cycle return the old value,
  // which is exactly what the flop array gives without any bypass.
  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: datapath, ALU and control FSM in one block.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per wait cycle.
// Backpressure: memory stalls via mem_ready; request held until accepted.
// Ports: clk, reset (async, active-low); memory port mem_req/mem_we/
// mem_addr/mem_wdata (registered) with mem_rdata/mem_ready; status outputs
// retire (one pulse per instruction), halted (sticky), pc (debug).
module mc_core
  import mc_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] pc
);

  mc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  instr_t          ir_q, ir_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] aluout_q, aluout_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  logic [XLEN-1:0] imm_sext, br_off, jmp_tgt, pc_plus4;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  alu_ctl_t        alu_op;
  logic            mem_done;

  mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk (clk),
    .ra1 (ir_q.rs),
    .ra2 (ir_q.rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  assign imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {imm_sext[XLEN-3:0], 2'b00};
  // pc_q already holds PC+4 once the instruction has been fetched.
  assign jmp_tgt  = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
  assign pc_plus4 = pc_q + XLEN'(4);

  // ready only counts while a request is actually outstanding.
  assign mem_done = mem_req_q && mem_ready;

  // ALU operand selection. DECODE reuses the ALU for the branch target.
  always_comb begin
    alu_a  = a_q;
    alu_b  = imm_sext;
    alu_op = ALU_ADD;
    case (state_q)
      ST_DECODE: begin
        alu_a = pc_q;
        alu_b = br_off;
      end
      ST_EXEC: begin
        alu_b  = b_q;
        alu_op = funct_to_alu(ir_q.funct);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y[0] = ($signed(alu_a) < $signed(alu_b));
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Next-state, datapath register updates and registered memory port.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_wa    = ir_q.rt;
    rf_wd    = aluout_q;
    retire   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_plus4;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d      = rf_rd1;
        b_d      = rf_rd2;
        aluout_d = alu_y;
        case (ir_q.op)
          OP_RTYPE: state_d = funct_legal(ir_q.funct) ? ST_EXEC : ST_HALT;
          OP_LW,
          OP_SW:    state_d = ST_MEMADR;
          OP_BEQ:   state_d = ST_BRANCH;
          OP_ADDI:  state_d = ST_ADDIEX;
          OP_J:     state_d = ST_JUMP;
          default:  state_d = ST_HALT;
        endcase
      end
      ST_MEMADR: begin
        aluout_d = alu_y;
        state_d  = (ir_q.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        if (mem_done) begin
          mdr_d   = mem_rdata;
          state_d = ST_MEMWB;
        end
      end
      ST_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        if (mem_done) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        aluout_d = alu_y;
        state_d  = ST_ALUWB;
      end
      ST_ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = ir_q.rd;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDIEX: begin
        aluout_d = alu_y;
        state_d  = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        if (a_q == b_q) begin
          pc_d = aluout_q;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pc_d    = jmp_tgt;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    // Request is raised for the cycle we enter (or stay in) a memory state,
    // but never in the cycle right after a completion: a transfer that just
    // finished always leaves one idle cycle before the next request, even
    // when MEMWR hands straight back to FETCH.
    mem_req_d   = is_mem_state(state_d) && !mem_done;
    mem_we_d    = mem_req_d && (state_d == ST_MEMWR);
    mem_addr_d  = (state_d == ST_FETCH) ? pc_d : aluout_d;
    mem_wdata_d = b_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aluout_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluout_q    <= aluout_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;

endmodule

// File: tb/tb_mc_core.sv
// Testbench for mc_core at XLEN=32, RESET_PC=0x100, with a behavioural
// unified memory that inserts configurable wait states on data accesses.
module tb_mc_core;

  localparam int          XLEN    = 32;
  localparam logic [31:0] RST_PC  = 32'h100;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req, mem_we, mem_ready, retire, halted;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata, pc;

  mc_core #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .halted    (halted),
    .pc        (pc)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  int          data_wait   = 0;
  bit          idle_toggle = 1'b0;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          ret_cnt = 0;

  function automatic int waits_for(input logic [31:0] a);
    return (a < 32'h100) ? data_wait : 0;
  endfunction

  initial begin : memmodel
    int          wcnt;
    bit          served;
    logic [31:0] c_addr, c_wd;
    logic        c_we;
    wcnt = 0; served = 1'b0; c_addr = '0; c_wd = '0; c_we = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (served) chk1("req_drop_after_ready", mem_req, 1'b0);
      served = 1'b0;
      if (!mem_req) begin
        wcnt = 0;
        mem_ready = idle_toggle ? ~mem_ready : 1'b0;
      end else begin
        if (wcnt == 0) begin
          c_addr = mem_addr; c_we = mem_we; c_wd = mem_wdata;
        end else begin
          chk("req_addr_stable", mem_addr, c_addr);
          chk1("req_we_stable", mem_we, c_we);
          if (c_we) chk("req_wdata_stable", mem_wdata, c_wd);
        end
        if (wcnt < waits_for(c_addr)) begin
          mem_ready = 1'b0;
          wcnt++;
        end else begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
            rd_log.push_back(mem_addr);
          end
          served = 1'b1;
          wcnt = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (retire === 1'b1) ret_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] j_type(input logic [25:0] t);
    return {6'd2, t};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Holds reset across one rising edge, checks reset outputs, then releases.
  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_retire", retire, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_pc", pc, RST_PC);
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    ret_cnt = 0;
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    chk1(name, halted, 1'b1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          n_ret, cnt;
    logic [31:0] exp_fetch[9];

    // R-type vectors: $1 = sext(a), $2 = sext(b), $3 = $1 op $2.
    vecs[0]  = '{16'd5,      16'hFFFD, 6'd32, 32'h0000_0002};
    vecs[1]  = '{16'd5,      16'hFFFD, 6'd34, 32'h0000_0008};
    vecs[2]  = '{16'h0F0F,   16'h00FF, 6'd36, 32'h0000_000F};
    vecs[3]  = '{16'h0F00,   16'h00F0, 6'd37, 32'h0000_0FF0};
    vecs[4]  = '{16'hFFFD,   16'd5,    6'd42, 32'h0000_0001};
    vecs[5]  = '{16'd5,      16'hFFFD, 6'd42, 32'h0000_0000};
    vecs[6]  = '{16'd0,      16'd1,    6'd34, 32'hFFFF_FFFF};
    vecs[7]  = '{16'h7FFF,   16'h7FFF, 6'd32, 32'h0000_FFFE};
    vecs[8]  = '{16'hFFFF,   16'hFFFF, 6'd42, 32'h0000_0000};
    vecs[9]  = '{16'hFFFF,   16'h8000, 6'd36, 32'hFFFF_8000};
    vecs[10] = '{16'h8000,   16'd1,    6'd34, 32'hFFFF_7FFF};

    // ---- Test 1: reset, first fetch, arithmetic program, sw/lw with waits ----
    clear_mem();
    put(32'h100, i_type(6'd8, 5'd0, 5'd1, 16'd5));       // addi $1,$0,5
    put(32'h104, i_type(6'd8, 5'd0, 5'd2, 16'hFFFD));    // addi $2,$0,-3
    put(32'h108, r_type(6'd32, 5'd1, 5'd2, 5'd3));       // add  $3,$1,$2
    put(32'h10C, r_type(6'd42, 5'd2, 5'd1, 5'd4));       // slt  $4,$2,$1
    put(32'h110, i_type(6'd43, 5'd0, 5'd3, 16'd8));      // sw   $3,8($0)
    put(32'h114, i_type(6'd43, 5'd0, 5'd4, 16'd12));     // sw   $4,12($0)
    put(32'h118, i_type(6'd35, 5'd0, 5'd5, 16'd8));      // lw   $5,8($0)
    put(32'h11C, i_type(6'd43, 5'd0, 5'd5, 16'd16));     // sw   $5,16($0)
    put(32'h120, ILLEGAL);
    data_wait = 3;
    apply_reset();

    tick();
    chk1("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, RST_PC);
    n_ret = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      if (c == 2) chk("pc_after_fetch", pc, 32'h104);
      if (retire) n_ret++;
    end
    chk("retires_in_16", 32'(n_ret), 32'd4);

    cnt = 0;
    while (!(mem_req && mem_addr == 32'h118) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk1("lw_fetch_seen", mem_req, 1'b1);
    cnt = 1;
    while (!retire && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("lw_cycles", 32'(cnt), 32'd8);

    wait_halt("prog1_halt", 200);
    chk("prog1_nwrites", 32'(wa_log.size()), 32'd3);
    if (wa_log.size() >= 3) begin
      chk("sw3_addr", wa_log[0], 32'h8);
      chk("sw3_data", wd_log[0], 32'h2);
      chk("sw4_addr", wa_log[1], 32'hC);
      chk("sw4_data", wd_log[1], 32'h1);
      chk("sw5_addr", wa_log[2], 32'h10);
      chk("sw5_data", wd_log[2], 32'h2);
    end
    chk("prog1_retires", 32'(ret_cnt), 32'd8);

    // Halted: no requests and no retires even with ready toggling.
    idle_toggle = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk1("halt_no_req", mem_req, 1'b0);
      chk1("halt_no_retire", retire, 1'b0);
    end
    idle_toggle = 1'b0;

    // ---- Test 2: illegal opcode 0x3F, halted rises after DECODE ----
    clear_mem();
    put(32'h100, ILLEGAL);
    data_wait = 0;
    apply_reset();                     // also checks that halted cleared
    tick();
    chk1("ill_fetch_req", mem_req, 1'b1);
    chk1("ill_halted_fetch", halted, 1'b0);
    tick();
    chk1("ill_halted_decode", halted, 1'b0);
    tick();
    chk1("ill_halted_after", halted, 1'b1);
    chk1("ill_no_req", mem_req, 1'b0);

    // Unsupported R funct (xor) also halts without writing anything.
    clear_mem();
    put(32'h100, r_type(6'd38, 5'd0, 5'd0, 5'd1));
    put(32'h104, i_type(6'd43, 5'd0, 5'd0, 16'd0));
    apply_reset();
    wait_halt("xor_halt", 20);
    chk("xor_retires", 32'(ret_cnt), 32'd0);

    // ---- Test 3: table-driven ALU vectors ----
    for (int i = 0; i < 11; i++) begin
      clear_mem();
      put(32'h100, i_type(6'd8, 5'd0, 5'd1, vecs[i].a));
      put(32'h104, i_type(6'd8, 5'd0, 5'd2, vecs[i].b));
      put(32'h108, r_type(vecs[i].fn, 5'd1, 5'd2, 5'd3));
      put(32'h10C, i_type(6'd43, 5'd0, 5'd3, 16'd0));
      put(32'h110, ILLEGAL);
      data_wait   = i % 3;
      idle_toggle = (i % 2) == 1;
      apply_reset();
      wait_halt("vec_halt", 100);
      chk("vec_nwrites", 32'(wa_log.size()), 32'd1);
      if (wa_log.size() == 1) chk("vec_result", wd_log[0], vecs[i].exp);
    end
    idle_toggle = 1'b0;

    // $0 stays zero after a write attempt.
    clear_mem();
    put(32'h100, i_type(6'd8, 5'd0, 5'd0, 16'd7));      // addi $0,$0,7
    put(32'h104, i_type(6'd43, 5'd0, 5'd0, 16'd4));     // sw $0,4($0)
    put(32'h108, ILLEGAL);
    data_wait = 0;
    apply_reset();
    wait_halt("r0_halt", 50);
    if (wd_log.size() == 1) chk("r0_data", wd_log[0], 32'h0);
    else chk("r0_nwrites", 32'(wd_log.size()), 32'd1);

    // ---- Test 4: jump and branches ----
    clear_mem();
    put(32'h100, j_type(26'h10));                        // j 0x40
    put(32'h040, i_type(6'd8, 5'd0, 5'd1, 16'd1));       // addi $1,$0,1
    put(32'h044, i_type(6'd8, 5'd0, 5'd2, 16'd0));       // addi $2,$0,0
    put(32'h048, j_type(26'h8));                         // j 0x20
    put(32'h020, i_type(6'd4, 5'd1, 5'd2, 16'hFFFE));    // beq $1,$2,-2
    put(32'h024, i_type(6'd8, 5'd0, 5'd2, 16'd1));       // addi $2,$0,1
    put(32'h028, j_type(26'h8));                         // j 0x20
    put(32'h01C, ILLEGAL);
    exp_fetch = '{32'h100, 32'h40, 32'h44, 32'h48, 32'h20,
                  32'h24, 32'h28, 32'h20, 32'h1C};
    apply_reset();
    wait_halt("br_halt", 150);
    chk("br_nfetch", 32'(rd_log.size()), 32'd9);
    if (rd_log.size() == 9) begin
      for (int k = 0; k < 9; k++) chk("br_fetch_addr", rd_log[k], exp_fetch[k]);
    end
    chk("br_retires", 32'(ret_cnt), 32'd8);

    // ---- Test 5: reset while MEMWR is waiting ----
    clear_mem();
    put(32'h100, i_type(6'd8, 5'd0, 5'd1, 16'd9));       // addi $1,$0,9
    put(32'h104, i_type(6'd43, 5'd0, 5'd1, 16'd4));      // sw $1,4($0)
    put(32'h108, ILLEGAL);
    data_wait = 10;
    apply_reset();
    cnt = 0;
    while (!(mem_req && mem_we) && cnt < 50) begin
      tick();
      cnt++;
    end
    chk1("mw_write_req", mem_we, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk1("mw_async_drop", mem_req, 1'b0);
    tick();
    reset = 1'b1;
    cnt = 0;
    while (!mem_req && cnt < 10) begin
      tick();
      cnt++;
    end
    chk1("mw_refetch_req", mem_req, 1'b1);
    chk("mw_refetch_addr", mem_addr, RST_PC);
    chk("mw_no_write", 32'(wa_log.size()), 32'd0);
    chk1("mw_not_halted", halted, 1'b0);
    wait_halt("mw_halt", 100);
    chk("mw_nwrites", 32'(wa_log.size()), 32'd1);
    if (wa_log.size() == 1) chk("mw_data", wd_log[0], 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS-subset core: datapath and its control FSM merged into one block, width set by `XLEN`. Unlike the fixed 64-bit datapath with an external controller, it talks to memory over a `req`/`ready` handshake with unbounded wait states. It reports retirement, detects illegal opcodes and halts on them. It sits between the top-level wrapper and a single unified instruction/data memory.

## Interface
- `XLEN`, 64: datapath, register and address width; legal values 32 or 64.
- `RESET_PC`, 0: PC value loaded on reset; must be a multiple of 4.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `mem_req`, output, 1: memory access request; held until accepted.
- `mem_we`, output, 1: 1 means write; valid while `mem_req`=1.
- `mem_addr`, output, XLEN: byte address; valid while `mem_req`=1.
- `mem_wdata`, output, XLEN: store data; valid while `mem_we`=1.
- `mem_rdata`, input, XLEN: read data; sampled on the edge where `mem_req`=1 and `mem_ready`=1. Instructions use bits [31:0].
- `mem_ready`, input, 1: memory completes the current request this cycle.
- `retire`, output, 1: one-cycle pulse in the final cycle of each instruction.
- `halted`, output, 1: sticky; set when an illegal opcode is decoded.
- `pc`, output, XLEN: current PC, for debug.

## Operation
- Supported instructions:
  - R-type (op 0): funct 32 add, 34 sub, 36 and, 37 or, 42 slt.
  - lw (35), sw (43), beq (4), addi (8), j (2).
  - Any other op, or an unsupported R funct, enters HALT.
- Register file: 32×XLEN. Reads are combinational. Reg 0 always reads 0, and writes to it are dropped.
- Immediates are sign-extended from 16 bits to XLEN. Branch offset is the sign-extended immediate shifted left 2.
- Jump target: {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
- All arithmetic is modulo 2^XLEN. slt is a signed XLEN compare and writes 0 or 1.
- Internal registers: IR (32b), MDR, A, B, ALUOut.
- FSM states:
  - FETCH: issue read at PC. On ready: load IR, PC←PC+4.
  - DECODE: latch A and B; ALUOut←PC+branch offset; dispatch on op.
  - MEMADR: ALUOut←A+imm. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: issue read at ALUOut. On ready: MDR←rdata, go to MEMWB.
  - MEMWB: rt←MDR; retire.
  - MEMWR: issue write of B to ALUOut. On ready: retire.
  - EXEC: ALUOut←A op B.
  - ALUWB: rd←ALUOut; retire.
  - ADDIEX: ALUOut←A+imm.
  - ADDIWB: rt←ALUOut; retire.
  - BRANCH: if A==B then PC←ALUOut; retire either way.
  - JUMP: PC←target; retire.
  - HALT: terminal; `halted`=1; no requests; leaves only on reset.
- After a retire state the FSM returns to FETCH.

## Timing
- Reset values: state FETCH; PC=RESET_PC; IR, MDR, A, B and ALUOut = 0; `mem_req`=0 for the reset cycle; `retire`=0; `halted`=0. Register file contents are not reset.
- Cycles per instruction with zero wait (count from FETCH entry through the retire cycle):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each wait cycle on `mem_ready` adds 1.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered outputs. They are stable from the first request cycle through the ready cycle.
- `mem_req` drops in the cycle after ready. There are no back-to-back requests: the earliest next request comes 1 cycle later.
- `mem_ready` while `mem_req`=0 is ignored.
- `retire` is high in exactly one cycle per completed instruction: MEMWB, the MEMWR ready cycle, ALUWB, ADDIWB, BRANCH or JUMP.
- Reset asserted mid-access: abandon the request immediately (async), return to FETCH at RESET_PC, perform no register or PC writeback.
- A register write and a read of the same register in the same cycle return the old value. No forwarding is needed, because A and B are latched in DECODE.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct localparams
  - state enum `mc_state_t`
  - 3-bit ALU control encoding (add, sub, and, or, slt)
- Sub-module `mc_regfile #(XLEN)`: 2 read ports, 1 write port, reg 0 hardwired to zero.
- ALU, muxes and the FSM live inline in `mc_core`.

## Test plan
- Reset, zero-wait memory: first `mem_addr` = RESET_PC = 0x100. After one fetch, `pc` = 0x104.
- Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1. Expect $3=2 and $4=1. Exactly 4 `retire` pulses in 16 cycles.
- sw $3,8($0) then lw $5,8($0), with memory inserting 3 wait cycles per access. Expect write of 2 at 0x8, then $5=2. `mem_req` is held stable through each wait; lw takes 8 cycles.
- beq taken with offset −2 from 0x20, landing at 0x1C; beq not taken continues at 0x24. j 0x40 at XLEN=32 lands at 0x40.
- Opcode 0x3F: `halted` rises after DECODE. Afterwards no `mem_req` and no `retire`, even with `mem_ready` toggling.
- Reset pulse while MEMWR is waiting: no write completes, the FSM refetches at RESET_PC, and `halted` clears.
